axi4_slave_regfile: RTL and testbench
=====================================

Name: axi4_slave_regfile

Overview:
AXI4 memory-mapped slave register file that sits directly downstream of the UART-to-AXI bridge master port. It terminates the bridge's m_axi_* bus and gives host software a bank of 32-bit read/write registers. It supports FIXED and INCR bursts up to 256 beats and returns per-burst error responses. Read and write channels run independently.

Parameters:
NUM_REGS, 16, number of 32-bit registers; must be a power of two, 2..256
BASE_ADDR, 32'h0000_0000, byte address of register 0; must be aligned to NUM_REGS*4
RESET_VALUE, 32'h0000_0000, value loaded into every register on reset

Ports:
aclk  in  1  clock; all logic on the rising edge
aresetn  in  1  reset, synchronous, active-low
s_axi_awvalid/awready  in/out  1/1  write address handshake
s_axi_awaddr  in  32  write start byte address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  beat size; only 3'b010 is legal
s_axi_awburst  in  2  00 FIXED, 01 INCR, others illegal
s_axi_awlock/awcache/awprot/awqos  in  1/4/3/4  accepted and ignored
s_axi_wvalid/wready  in/out  1/1  write data handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wlast  in  1  last write beat
s_axi_bvalid/bready  out/in  1/1  write response handshake
s_axi_bresp  out  2  write response
s_axi_arvalid/arready  in/out  1/1  read address handshake
s_axi_araddr/arlen/arsize/arburst  in  32/8/3/2  same meaning as AW
s_axi_arlock/arcache/arprot/arqos  in  1/4/3/4  ignored
s_axi_rvalid/rready  out/in  1/1  read data handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat

Behaviour:
- Reset (aresetn=0 at a clock edge): all registers = RESET_VALUE; both FSMs go to idle. awready, arready, wready, bvalid, rvalid and rlast = 0; bresp, rresp and rdata = 0. awready and arready rise on the first edge with aresetn=1. Reset mid-burst drops the burst silently; no B or R response is issued.
- Address decode: idx = (addr - BASE_ADDR) >> 2.
  - Word is in range iff BASE_ADDR <= addr < BASE_ADDR + NUM_REGS*4.
  - addr[1:0] are ignored.
  - INCR adds 4 per beat in 32-bit arithmetic; FIXED keeps the address constant.
  - Range is checked per beat.
- Response codes: OKAY=00, SLVERR=10, DECERR=11.
  - SLVERR if awsize/arsize != 010 or burst is not 00/01. In this case no register is written, and read data is 0.
  - Otherwise, a beat out of range gives DECERR: the write is discarded, read data is 0.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch address, len, burst and size check; beat count = 0. Next state W_DATA (awready=0, wready=1 on the next cycle).
  - W_DATA: on each W handshake, write bytes where wstrb[i]=1 to reg[idx]; the new value is visible from the next cycle.
    - Beat count == len ends the burst regardless of wlast.
    - wlast mismatch (early or missing on the final beat) sets SLVERR for the burst.
    - On the final handshake: wready=0 and bvalid=1 on the next cycle.
  - W_RESP: bvalid held with a stable bresp until bready. bresp = highest-priority error seen in the burst (SLVERR > DECERR > OKAY). After the B handshake, awready=1 on the next cycle.
- Read FSM, states R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On AR handshake, latch the burst. On the next cycle: rvalid=1, rdata = registered value of beat 0, rresp set for beat 0, rlast = (len==0).
  - R_DATA: rdata/rresp/rlast are held stable while rvalid && !rready. On each handshake of a non-last beat, the next beat's data is loaded on the same edge, so there is zero bubble.
    - After the last-beat handshake: rvalid=0, rlast=0, arready=1 on the next cycle.
    - rresp is per beat.
- Same-cycle write and read-load of the same register: rdata captures the old value.
- Read and write FSMs are fully concurrent; there is no ordering between channels.
- Throughput: 1 beat/cycle per channel. One idle cycle between bursts on each channel.

Test Plan:
- Reset, then AW addr=0x8 len=0 INCR size=2, W 0xDEADBEEF strb=F wlast=1 -> bvalid 1 cycle after the W beat, bresp=00. Then AR addr=0x8 -> rdata=0xDEADBEEF, rresp=00, rlast=1.
- INCR write of len=3 at 0x0 with data 1,2,3,4, strb on beat 2 = 4'b0011, reg2 preloaded 0xAAAAAAAA -> read back len=3 returns 1,2,0xAAAA0003,4, with rlast on the 4th beat only.
- With NUM_REGS=16, INCR read addr=0x38 len=3 -> beats rresp 00,00,11,11; data reg14, reg15, 0, 0; rlast on beat 4. A write over the same range -> bresp=11 and reg14/reg15 are updated.
- awsize=3'b001 write of 0x55 to 0x4 -> bresp=10 and reg1 is unchanged. arburst=2'b10 len=1 -> two beats, rdata=0, rresp=10.
- Random bready/rready backpressure (~50%) with concurrent 16-beat write and read bursts -> outputs stay stable while stalled and all data matches the model. wlast asserted early on beat 2 of 4 -> bresp=10 and exactly 4 beats are consumed.
- Assert aresetn=0 for 1 cycle mid 8-beat write after beat 3 -> all registers = RESET_VALUE, bvalid never asserts, awready=1 one cycle after reset release.

Source files
------------

// File: rtl/axi4_slave_regfile.sv
// -----------------------------------------------------------------------------
// axi4_slave_regfile
//
// AXI4 slave exposing a bank of NUM_REGS 32-bit read/write registers. Sits
// downstream of the UART-to-AXI bridge master. Supports FIXED and INCR bursts
// of 1..256 beats (32-bit beats only) with per-burst write responses and
// per-beat read responses. Read and write channels are fully independent.
//
// Ports:
//   aclk, aresetn         clock (rising edge), synchronous active-low reset
//   s_axi_aw*             write address channel (lock/cache/prot/qos ignored)
//   s_axi_w*              write data channel
//   s_axi_b*              write response channel
//   s_axi_ar*             read address channel (lock/cache/prot/qos ignored)
//   s_axi_r*              read data channel
//   wr_state_dbg          current write FSM state (W_IDLE=0, W_DATA=1, W_RESP=2)
//   rd_state_dbg          current read FSM state (R_IDLE=0, R_DATA=1)
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// valid and ready are both 1. A source never drops valid or changes payload
// while valid && !ready; all ready/valid outputs here are registered.
//
// Responses: OKAY=00, SLVERR=10 (bad size/burst or wlast mismatch),
// DECERR=11 (beat address outside the register window). For writes the
// burst response is the worst seen (SLVERR over DECERR over OKAY).
// -----------------------------------------------------------------------------
module axi4_slave_regfile #(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awlock,
    input  logic [3:0]  s_axi_awcache,
    input  logic [2:0]  s_axi_awprot,
    input  logic [3:0]  s_axi_awqos,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arlock,
    input  logic [3:0]  s_axi_arcache,
    input  logic [2:0]  s_axi_arprot,
    input  logic [3:0]  s_axi_arqos,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic [1:0]  wr_state_dbg,
    output logic        rd_state_dbg
);

    localparam int          IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] SPAN        = 32'(NUM_REGS * 4);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    logic [31:0] regs [NUM_REGS];

    // Sideband attributes carry no meaning for a plain register bank.
    logic unused_attr;
    assign unused_attr = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    // ------------------------------------------------------------------ write
    w_state_t       w_state, w_next;
    logic [31:0]    w_addr;
    logic [7:0]     w_len, w_cnt;
    logic           w_incr, w_bad, w_slv, w_dec;
    logic           aw_hs, w_hs, b_hs, w_final, w_mismatch;
    logic [31:0]    w_off;
    logic           w_in_range;
    logic [IDX_W-1:0] w_idx;

    assign aw_hs      = s_axi_awvalid && s_axi_awready;
    assign w_hs       = s_axi_wvalid && s_axi_wready;
    assign b_hs       = s_axi_bvalid && s_axi_bready;
    assign w_final    = (w_cnt == w_len);
    assign w_mismatch = (s_axi_wlast != w_final);
    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign w_off      = w_addr - BASE_ADDR;
    assign w_in_range = (w_off < SPAN);
    assign w_idx      = w_off[IDX_W+1:2];
    assign wr_state_dbg = w_state;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_incr        <= 1'b0;
            w_bad         <= 1'b0;
            w_slv         <= 1'b0;
            w_dec         <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
        end else begin
            w_state       <= w_next;
            // Channel flags follow the state being entered, so they are valid
            // from the first cycle of that state.
            s_axi_awready <= (w_next == W_IDLE);
            s_axi_wready  <= (w_next == W_DATA);
            s_axi_bvalid  <= (w_next == W_RESP);

            if (aw_hs) begin
                w_addr <= s_axi_awaddr;
                w_len  <= s_axi_awlen;
                w_cnt  <= '0;
                w_incr <= (s_axi_awburst == 2'b01);
                w_bad  <= (s_axi_awsize != 3'b010) || s_axi_awburst[1];
                w_slv  <= 1'b0;
                w_dec  <= 1'b0;
            end

            if (w_hs) begin
                if (!w_bad && w_in_range) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_axi_wstrb[b]) regs[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                    end
                end
                w_cnt <= w_cnt + 8'd1;
                if (w_incr) w_addr <= w_addr + 32'd4;
                w_slv <= w_slv | w_mismatch;
                w_dec <= w_dec | !w_in_range;
                // Fold in this beat's status directly; the sticky flags only
                // reflect earlier beats at this point.
                if (w_final) begin
                    if (w_bad || w_slv || w_mismatch)
                        s_axi_bresp <= RESP_SLVERR;
                    else if (w_dec || !w_in_range)
                        s_axi_bresp <= RESP_DECERR;
                    else
                        s_axi_bresp <= RESP_OKAY;
                end
            end
        end
    end

    // ------------------------------------------------------------------- read
    r_state_t       r_state, r_next;
    logic [31:0]    r_addr;
    logic [7:0]     r_len, r_cnt;
    logic           r_incr, r_bad;
    logic           ar_hs, r_hs, ar_bad;
    logic [31:0]    ld_addr, ld_off, ld_data;
    logic           ld_bad, ld_in_range;
    logic [1:0]     ld_resp;
    logic [IDX_W-1:0] ld_idx;

    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign r_hs   = s_axi_rvalid && s_axi_rready;
    assign ar_bad = (s_axi_arsize != 3'b010) || s_axi_arburst[1];
    assign rd_state_dbg = r_state;

    // Beat being loaded into the output register: beat 0 comes straight from
    // the AR channel, later beats from the address of the beat just taken.
    always_comb begin
        ld_addr = r_incr ? (r_addr + 32'd4) : r_addr;
        ld_bad  = r_bad;
        if (ar_hs) begin
            ld_addr = s_axi_araddr;
            ld_bad  = ar_bad;
        end
    end

    assign ld_off      = ld_addr - BASE_ADDR;
    assign ld_in_range = (ld_off < SPAN);
    assign ld_idx      = ld_off[IDX_W+1:2];
    assign ld_data     = (!ld_bad && ld_in_range) ? regs[ld_idx] : 32'h0;
    assign ld_resp     = ld_bad ? RESP_SLVERR : (ld_in_range ? RESP_OKAY : RESP_DECERR);

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && s_axi_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_incr        <= 1'b0;
            r_bad         <= 1'b0;
        end else begin
            r_state       <= r_next;
            s_axi_arready <= (r_next == R_IDLE);
            s_axi_rvalid  <= (r_next == R_DATA);

            if (ar_hs) begin
                r_addr      <= s_axi_araddr;
                r_len       <= s_axi_arlen;
                r_cnt       <= '0;
                r_incr      <= (s_axi_arburst == 2'b01);
                r_bad       <= ar_bad;
                s_axi_rdata <= ld_data;
                s_axi_rresp <= ld_resp;
                s_axi_rlast <= (s_axi_arlen == 8'd0);
            end else if (r_hs) begin
                if (s_axi_rlast) begin
                    s_axi_rlast <= 1'b0;
                end else begin
                    r_addr      <= ld_addr;
                    r_cnt       <= r_cnt + 8'd1;
                    s_axi_rdata <= ld_data;
                    s_axi_rresp <= ld_resp;
                    s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_slave_regfile.sv
module tb_axi4_slave_regfile;

    localparam int          NUM_REGS = 16;
    localparam logic [31:0] BASE     = 32'h0000_0000;
    localparam logic [31:0] RSTV     = 32'h0000_0000;

    logic        aclk, aresetn;
    logic        awvalid, awready, awlock;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst;
    logic [3:0]  awcache, awqos;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready, arlock;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst;
    logic [3:0]  arcache, arqos;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [1:0]  wr_state_dbg;
    logic        rd_state_dbg;

    axi4_slave_regfile #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE), .RESET_VALUE(RSTV)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awlock(awlock), .s_axi_awcache(awcache), .s_axi_awprot(awprot),
        .s_axi_awqos(awqos),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arlock(arlock), .s_axi_arcache(arcache), .s_axi_arprot(arprot),
        .s_axi_arqos(arqos),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
    );

    // ------------------------------------------------------- clock and reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    // ----------------------------------------------------- reference model
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [NUM_REGS];
    logic [31:0] wdat [256];
    logic [3:0]  wstr [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [2:0] size, input logic [1:0] burst);
        return (size == 3'd2) && (burst == 2'b00 || burst == 2'b01);
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < {1'b0, BASE} + 33'(NUM_REGS * 4));
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int k);
        return (burst == 2'b01) ? a + 32'(4 * k) : a;
    endfunction

    function automatic int reg_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic expect_beat(input logic [31:0] a, input bit ok, output logic [31:0] d, output logic [1:0] r);
        if (!ok) begin d = 32'h0; r = 2'b10; end
        else if (!in_window(a)) begin d = 32'h0; r = 2'b11; end
        else begin d = model[reg_of(a)]; r = 2'b00; end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) model[i] = RSTV;
    endtask

    // --------------------------------------------------------- driver tasks
    // last_pos: beat index carrying wlast (-1 = never). bp: random bready.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int last_pos, input bit bp);
        bit ok = legal(size, burst);
        bit slv = !ok;
        bit dec = 0;
        bit done;
        int n;
        logic [31:0] a;
        logic [1:0] exp_b;
        @(negedge aclk);
        awvalid = 1; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        check({tag, ".awready"}, awready, 1);
        if (awready !== 1'b1) begin awvalid = 0; return; end
        @(negedge aclk);
        awvalid = 0;
        for (int k = 0; k <= int'(len); k++) begin
            wvalid = 1; wdata = wdat[k]; wstrb = wstr[k]; wlast = (k == last_pos);
            n = 0;
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            check({tag, ".wready"}, wready, 1);
            if (wready !== 1'b1) begin wvalid = 0; return; end
            a = beat_addr(addr, burst, k);
            if ((k == last_pos) != (k == int'(len))) slv = 1;
            if (!in_window(a)) dec = 1;
            @(posedge aclk);
            if (ok && in_window(a))
                for (int b = 0; b < 4; b++)
                    if (wstr[k][b]) model[reg_of(a)][8*b +: 8] = wdat[k][8*b +: 8];
            @(negedge aclk);
        end
        wvalid = 0; wlast = 0;
        check({tag, ".wready_off"}, wready, 0);
        exp_b = slv ? 2'b10 : (dec ? 2'b11 : 2'b00);
        done = 0; n = 0;
        while (!done) begin
            check({tag, ".bvalid"}, bvalid, 1);
            check({tag, ".bresp"}, bresp, exp_b);
            bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            if (bready) done = 1;
            else begin
                n++;
                if (n > 60) begin check({tag, ".bstall"}, 32'(n), 0); done = 1; end
            end
        end
        bready = 0;
        check({tag, ".bvalid_off"}, bvalid, 0);
        check({tag, ".awready_back"}, awready, 1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit bp);
        bit ok = legal(size, burst);
        bit done;
        int n;
        logic [31:0] ed, nd;
        logic [1:0] er, nr;
        @(negedge aclk);
        arvalid = 1; araddr = addr; arlen = len; arsize = size; arburst = burst;
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        check({tag, ".arready"}, arready, 1);
        if (arready !== 1'b1) begin arvalid = 0; return; end
        expect_beat(beat_addr(addr, burst, 0), ok, ed, er);
        @(negedge aclk);
        arvalid = 0;
        for (int k = 0; k <= int'(len); k++) begin
            done = 0; n = 0;
            nd = ed; nr = er;
            while (!done) begin
                check($sformatf("%s.rvalid[%0d]", tag, k), rvalid, 1);
                check($sformatf("%s.rdata[%0d]", tag, k), rdata, ed);
                check($sformatf("%s.rresp[%0d]", tag, k), rresp, er);
                check($sformatf("%s.rlast[%0d]", tag, k), rlast, (k == int'(len)));
                rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                // The next beat is captured on this coming edge, before any
                // write landing on the same edge.
                if (rready && k < int'(len)) expect_beat(beat_addr(addr, burst, k + 1), ok, nd, nr);
                @(negedge aclk);
                if (rready) done = 1;
                else begin
                    n++;
                    if (n > 60) begin check({tag, ".rstall"}, 32'(n), 0); return; end
                end
            end
            ed = nd; er = nr;
        end
        rready = 0;
        check({tag, ".rvalid_off"}, rvalid, 0);
        check({tag, ".rlast_off"}, rlast, 0);
        check({tag, ".arready_back"}, arready, 1);
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) begin
            wdat[k] = $urandom;
            wstr[k] = 4'($urandom_range(0, 15));
        end
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        int n;
        logic [31:0] ra;
        logic [7:0]  rl;
        logic [1:0]  rb;
        logic [2:0]  rs;

        aresetn = 0;
        awvalid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01;
        awlock = 0; awcache = 0; awprot = 0; awqos = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01;
        arlock = 0; arcache = 0; arprot = 0; arqos = 0; rready = 0;
        model_reset();

        // Reset values
        repeat (3) @(negedge aclk);
        check("rst.awready", awready, 0);
        check("rst.arready", arready, 0);
        check("rst.wready", wready, 0);
        check("rst.bvalid", bvalid, 0);
        check("rst.rvalid", rvalid, 0);
        check("rst.rlast", rlast, 0);
        check("rst.bresp", bresp, 0);
        check("rst.rresp", rresp, 0);
        check("rst.rdata", rdata, 0);
        aresetn = 1;
        @(negedge aclk);
        check("rst.awready_up", awready, 1);
        check("rst.arready_up", arready, 1);

        // Single-beat write and read-back
        wdat[0] = 32'hDEADBEEF; wstr[0] = 4'hF;
        do_write("single_w", 32'h8, 8'd0, 3'd2, 2'b01, 0, 0);
        do_read("single_r", 32'h8, 8'd0, 3'd2, 2'b01, 0);

        // Byte strobes over a preloaded register
        wdat[0] = 32'hAAAAAAAA; wstr[0] = 4'hF;
        do_write("preload", 32'h8, 8'd0, 3'd2, 2'b01, 0, 0);
        wdat[0] = 32'd1; wdat[1] = 32'd2; wdat[2] = 32'd3; wdat[3] = 32'd4;
        wstr[0] = 4'hF;  wstr[1] = 4'hF;  wstr[2] = 4'b0011; wstr[3] = 4'hF;
        do_write("strb_w", 32'h0, 8'd3, 3'd2, 2'b01, 3, 0);
        do_read("strb_r", 32'h0, 8'd3, 3'd2, 2'b01, 0);

        // Burst running off the top of the window
        fill_random(2);
        wstr[0] = 4'hF; wstr[1] = 4'hF;
        do_write("top_pre", 32'h38, 8'd1, 3'd2, 2'b01, 1, 0);
        do_read("top_r", 32'h38, 8'd3, 3'd2, 2'b01, 0);
        fill_random(4);
        do_write("top_w", 32'h38, 8'd3, 3'd2, 2'b01, 3, 0);
        do_read("top_r2", 32'h38, 8'd3, 3'd2, 2'b01, 0);

        // Illegal size / burst type
        wdat[0] = 32'h55; wstr[0] = 4'hF;
        do_write("bad_size_w", 32'h4, 8'd0, 3'd1, 2'b01, 0, 0);
        do_read("bad_size_chk", 32'h4, 8'd0, 3'd2, 2'b01, 0);
        do_read("bad_burst_r", 32'h0, 8'd1, 3'd2, 2'b10, 0);

        // wlast early on beat 2 of 4, and missing on the final beat
        fill_random(4);
        do_write("early_last", 32'h10, 8'd3, 3'd2, 2'b01, 1, 0);
        fill_random(2);
        do_write("no_last", 32'h20, 8'd1, 3'd2, 2'b01, -1, 0);

        // Concurrent 16-beat bursts with random backpressure on both channels
        fill_random(16);
        fork
            do_write("conc_w", 32'h0, 8'd15, 3'd2, 2'b01, 15, 1);
            do_read("conc_r", 32'h0, 8'd15, 3'd2, 2'b01, 1);
        join
        do_read("conc_chk", 32'h0, 8'd15, 3'd2, 2'b01, 1);

        // Random bursts, including FIXED, illegal types and out-of-range starts
        for (int t = 0; t < 8; t++) begin
            ra = 32'($urandom_range(0, 20)) * 4;
            rl = 8'($urandom_range(0, 7));
            rb = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
            rs = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
            fill_random(int'(rl) + 1);
            do_write($sformatf("rnd_w%0d", t), ra, rl, rs, rb, int'(rl), 1);
            do_read($sformatf("rnd_r%0d", t), ra, rl, 3'd2, 2'b01, 1);
        end

        // Reset in the middle of an 8-beat write
        @(negedge aclk);
        awvalid = 1; awaddr = 32'h0; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        check("midrst.awready", awready, 1);
        @(negedge aclk);
        awvalid = 0;
        for (int k = 0; k < 3; k++) begin
            wvalid = 1; wdata = $urandom; wstrb = 4'hF; wlast = 0;
            n = 0;
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            check("midrst.wready", wready, 1);
            @(negedge aclk);
        end
        wvalid = 0;
        aresetn = 0;
        @(negedge aclk);
        aresetn = 1;
        model_reset();
        check("midrst.awready_in_rst", awready, 0);
        @(negedge aclk);
        check("midrst.awready_up", awready, 1);
        check("midrst.wready", wready, 0);
        for (int k = 0; k < 5; k++) begin
            check("midrst.bvalid", bvalid, 0);
            @(negedge aclk);
        end
        do_read("midrst_r", 32'h0, 8'd15, 3'd2, 2'b01, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
